mp_add_seq: RTL and testbench

Multi-precision add/subtract sequencer that streams operands as 16-bit limbs, least-significant limb first, into the combinational 16-bit Brent-Kung adder `brentkung`, registering the carry between limbs. It is the upstream driver of that adder: it presents `a`, `b`, `cin` and captures `sum` and `carry`. Results go to a downstream consumer through a registered valid/ready output. This turns the single-cycle 16-bit adder into an N×16-bit adder/subtractor at one limb per clock.

---
 rtl/mp_add_seq.sv | 99 +++++++++
 tb/tb_mp_add_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams 16-bit limbs LS-first through an
// external combinational adder, chaining the carry between limbs.
module mp_add_seq #(
  parameter int unsigned W    = 16,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic            in_first,
  input  logic            in_last,
  input  logic            in_sub,
  output logic [W-1:0]    add_a,
  output logic [W-1:0]    add_b,
  output logic            add_cin,
  input  logic [W-1:0]    add_sum,
  input  logic            add_cout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_sum,
  output logic [CNTW-1:0] out_idx,
  output logic            out_last,
  output logic            out_carry,
  output logic            out_ovf,
  output logic            out_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          r_state;
  logic            r_carry;
  logic            r_sub;
  logic [CNTW-1:0] r_idx;
  logic            r_out_valid;
  logic [W-1:0]    r_out_sum;
  logic            r_out_last;
  logic            r_out_carry;
  logic            r_out_ovf;
  logic            r_out_err;

  logic            w_start;
  logic            w_sub_eff;
  logic            w_accept;
  logic [W-1:0]    w_add_b;
  logic            w_ovf;

  // A limb in IDLE or one flagged first opens (or restarts) an operation.
  assign w_start   = (r_state == IDLE) || in_first;
  assign w_sub_eff = w_start ? in_sub : r_sub;
  assign w_add_b   = in_b ^ {W{w_sub_eff}};
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_ovf     = (in_a[W-1] == w_add_b[W-1]) && (add_sum[W-1] != in_a[W-1]);

  assign add_a   = in_a;
  assign add_b   = w_add_b;
  assign add_cin = w_start ? w_sub_eff : r_carry;

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_idx   = r_idx;
  assign out_last  = r_out_last;
  assign out_carry = r_out_carry;
  assign out_ovf   = r_out_ovf;
  assign out_err   = r_out_err;

  // Sequencer state and registered result slot; everything holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_carry     <= 1'b0;
      r_sub       <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_last  <= 1'b0;
      r_out_carry <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_carry     <= add_cout;
      r_sub       <= w_sub_eff;
      r_idx       <= w_start ? '0 : r_idx + CNTW'(1);
      r_out_valid <= 1'b1;
      r_out_sum   <= add_sum;
      r_out_last  <= in_last;
      r_out_carry <= in_last & add_cout;
      r_out_ovf   <= in_last & w_ovf;
      r_out_err   <= (r_state == BUSY) & in_first;
      r_state     <= in_last ? IDLE : BUSY;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq with a behavioural 16-bit adder on the add_* port.
module tb_mp_add_seq;

  localparam int unsigned W    = 16;
  localparam int unsigned CNTW = 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            in_first;
  logic            in_last;
  logic            in_sub;
  logic [W-1:0]    add_a;
  logic [W-1:0]    add_b;
  logic            add_cin;
  logic [W-1:0]    add_sum;
  logic            add_cout;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_sum;
  logic [CNTW-1:0] out_idx;
  logic            out_last;
  logic            out_carry;
  logic            out_ovf;
  logic            out_err;

  int checks = 0;
  int errors = 0;

  mp_add_seq #(.W(W), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_err(out_err)
  );

  // Stand-in for the combinational brentkung adder.
  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] sum, input logic [7:0] idx,
                         input logic last, input logic carry, input logic ovf, input logic err);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"},   32'(out_sum),   32'(sum));
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".last"},  32'(out_last),  32'(last));
    chk({tag, ".carry"}, 32'(out_carry), 32'(carry));
    chk({tag, ".ovf"},   32'(out_ovf),   32'(ovf));
    chk({tag, ".err"},   32'(out_err),   32'(err));
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic first, input logic last, input logic sub);
    in_a = a; in_b = b; in_first = first; in_last = last; in_sub = sub;
    in_valid = 1'b1;
  endtask

  // Present one limb at the falling edge, let it be accepted, sample 1 time unit after the edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic first, input logic last, input logic sub);
    @(negedge clk);
    drive(a, b, first, last, sub);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.sum",   32'(out_sum),   32'd0);
    chk("rst.idx",   32'(out_idx),   32'd0);
    chk("rst.flags", 32'({out_last, out_carry, out_ovf, out_err}), 32'd0);
    chk("rst.ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;

    // Single limb FFFF + 0001
    send(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
    chk_out("single", 16'h0000, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Three limbs 0001_FFFF_FFFF + 0000_0000_0001
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    chk_out("add3.l0", 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_out("add3.l1", 16'h0000, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk_out("add3.l2", 16'h0002, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Two limbs 0000_0000 - 0000_0001 (borrow out)
    send(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
    chk_out("sub2.l0", 16'hFFFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk_out("sub2.l1", 16'hFFFF, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Signed overflow both directions
    send(16'h7FFF, 16'h0001, 1'b1, 1'b1, 1'b0);
    chk_out("ovf.add", 16'h8000, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
    chk_out("ovf.sub", 16'h7FFF, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Backpressure: 4 limbs FFFF,0000,8000,0001 + 0002,0000,8000,0000
    send(16'hFFFF, 16'h0002, 1'b1, 1'b0, 1'b0);
    chk_out("bp.l0", 16'h0001, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.hold.sum", 32'(out_sum),  32'h0001);
      chk("bp.hold.idx", 32'(out_idx),  32'd0);
      chk("bp.hold.vld", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_out("bp.l1", 16'h0001, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    chk_out("bp.l2", 16'h0000, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk_out("bp.l3", 16'h0002, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("bp.drain", 32'(out_valid), 32'd0);

    // Restart: in_first mid-operation with a new subtract, then a closing limb
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    chk_out("rs.l0", 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1);
    chk_out("rs.restart", 16'h0002, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk_out("rs.close", 16'h0000, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation, then a limb without in_first starts fresh
    send(16'h1234, 16'h1111, 1'b1, 1'b0, 1'b0);
    chk_out("mr.l0", 16'h2345, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr.valid", 32'(out_valid), 32'd0);
    chk("mr.sum",   32'(out_sum),   32'd0);
    chk("mr.ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0005, 16'h0001, 1'b0, 1'b1, 1'b1);
    chk_out("mr.fresh", 16'h0004, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
